// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MDU_FAST_ZERO_EN: a zero b operand skips straight to FIX.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic               neg_q;       // result sign: sign(a) ^ sign(b)
    logic               rem_neg_q;   // remainder sign follows the dividend
    logic               bzero_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mcand_q;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;       // {partial product, multiplier} or {0, dividend/quotient}
    logic [WIDTH:0]     rem_q;

    // Operand magnitudes for signed ops; unsigned ops pass straight through.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One shift-add multiply step, multiplier consumed LSB first.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + ({1'b0, mcand_q} & {(WIDTH+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-division step, quotient produced MSB first.
    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;
    logic             div_ok;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    assign trial    = {rem_q, acc_q[WIDTH-1]};
    assign diff     = trial - {2'b00, mcand_q};
    assign div_ok   = ~diff[WIDTH+1];
    assign rem_next = div_ok ? diff[WIDTH:0] : trial[WIDTH:0];
    assign quo_next = {acc_q[WIDTH-2:0], div_ok};

    // Sign correction and result selection applied on the FIX edge.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (op_q[1]) begin
            if (bzero_q) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            a_q       <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        bzero_q   <= (b == '0);
                        a_q       <= a;
                        mcand_q   <= op[1] ? b_mag : a_mag;
                        acc_q     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        rem_q     <= '0;
                        cnt       <= '0;
`ifdef MDU_FAST_ZERO_EN
                        state     <= (b == '0) ? FIX : CALC;
`else
                        state     <= CALC;
`endif
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_q[1]) begin
                        acc_q[WIDTH-1:0] <= quo_next;
                        rem_q            <= rem_next;
                    end else begin
                        acc_q <= mul_next;
                    end
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter with hand-computed results.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

`ifdef MDU_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    // lat counts negedges after the start edge; bc counts busy samples before done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic inj, input logic with_hwe,
                         output int lat, output int bc, output logic [31:0] hi0);
        start = 1'b1; op = o; a = x; b = y; hi_we = with_hwe; wdata = 32'h0000DEAD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        hi0 = hi; lat = 0; bc = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            if (inj && lat == 4) begin
                start = 1'b1; op = 2'b10; hi_we = 1'b1; wdata = 32'h0000DEAD;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0; hi_we = 1'b0;
    endtask

    task automatic count_done(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    int lat, bc, seen;
    logic [31:0] hi0;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: multu max*max, latency, busy width, single-cycle done
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, lat, bc, hi0);
        check("t1_lat", lat, 33);
        check("t1_busy_cycles", bc, 33);
        check("t1_busy_at_done", {31'b0, busy}, 32'd0);
        check("t1_hi", hi, 32'hFFFFFFFE);
        check("t1_lo", lo, 32'h00000001);
        @(negedge clk);
        check("t1_done_pulse", {31'b0, done}, 32'd0);

        // 2: mult -3*7, then back-to-back divu 100/7
        do_op(2'b01, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, lat, bc, hi0);
        check("t2_mult_hi", hi, 32'hFFFFFFFF);
        check("t2_mult_lo", lo, 32'hFFFFFFEB);
        do_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, lat, bc, hi0);
        check("t2_b2b_lat", lat, 33);
        check("t2_divu_lo", lo, 32'd14);
        check("t2_divu_hi", hi, 32'd2);

        // 3: signed division sign handling
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, lat, bc, hi0);
        check("t3a_lo", lo, 32'hFFFFFFFD);
        check("t3a_hi", hi, 32'hFFFFFFFF);
        do_op(2'b11, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, lat, bc, hi0);
        check("t3b_lo", lo, 32'hFFFFFFFD);
        check("t3b_hi", hi, 32'd1);

        // 4: signed overflow and divide by zero
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, lat, bc, hi0);
        check("t4_ovf_lo", lo, 32'h80000000);
        check("t4_ovf_hi", hi, 32'd0);
        do_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, lat, bc, hi0);
        check("t4_dz_lat", lat, ZLAT);
        check("t4_dz_lo", lo, 32'hFFFFFFFF);
        check("t4_dz_hi", hi, 32'd5);

        // 5: start and hi_we ignored while busy; mtlo when idle; start beats hi_we
        do_op(2'b01, 32'd2, 32'd3, 1'b1, 1'b0, lat, bc, hi0);
        check("t5_hi_held", hi0, 32'd5);
        check("t5_lat", lat, 33);
        check("t5_hi", hi, 32'd0);
        check("t5_lo", lo, 32'd6);
        count_done(40, seen);
        check("t5_no_extra_done", seen, 0);
        lo_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        lo_we = 1'b0;
        check("t5_mtlo", lo, 32'h12345678);
        do_op(2'b00, 32'd4, 32'd5, 1'b0, 1'b1, lat, bc, hi0);
        check("t5_hi_we_dropped", hi0, 32'd0);
        check("t5_mul_lo", lo, 32'd20);

        // 6: reset mid-operation aborts
        hi_we = 1'b1; wdata = 32'h00000055;
        @(negedge clk);
        hi_we = 1'b0;
        check("t6_mthi", hi, 32'h00000055);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_hi", hi, 32'd0);
        check("t6_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(40, seen);
        check("t6_no_done", seen, 0);
        do_op(2'b00, 32'd4, 32'd5, 1'b0, 1'b0, lat, bc, hi0);
        check("t6_lat", lat, 33);
        check("t6_lo", lo, 32'd20);
        check("t6_hi", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
